// File: rtl/tnoc_axi_pkg.sv
// Shared types for the tnoc AXI bridges: response codes and the read tracker entry.
package tnoc_axi_pkg;

  typedef enum logic [1:0] {
    TNOC_AXI_OKAY   = 2'd0,
    TNOC_AXI_EXOKAY = 2'd1,
    TNOC_AXI_SLVERR = 2'd2,
    TNOC_AXI_DECERR = 2'd3
  } tnoc_axi_response;

  localparam logic [1:0] TNOC_AXI_DECERR_RESP = 2'(TNOC_AXI_DECERR);

  // Tracker fields are sized for the widest location id / tag any bridge instance uses.
  localparam int TNOC_AXI_MAX_ID_WIDTH  = 8;
  localparam int TNOC_AXI_MAX_TAG_WIDTH = 16;

  typedef struct packed {
    logic [TNOC_AXI_MAX_ID_WIDTH-1:0]  source_x;
    logic [TNOC_AXI_MAX_ID_WIDTH-1:0]  source_y;
    logic [TNOC_AXI_MAX_TAG_WIDTH-1:0] tag;
    logic                              error;
    logic [7:0]                        length;
  } tnoc_axi_read_tracker_entry;

endpackage

// File: rtl/tnoc_fifo.sv
// Generic FIFO with registered occupancy; pushes while full and pops while empty are ignored.
module tnoc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [COUNT_WIDTH-1:0] o_count
);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_q;
  logic [PTR_WIDTH-1:0]   wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q;
  logic [PTR_WIDTH-1:0]   rd_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   do_push;
  logic                   do_pop;

  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + PTR_WIDTH'(1);
  endfunction

  assign do_push = i_push && (count_q != COUNT_WIDTH'(DEPTH));
  assign do_pop  = i_pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == COUNT_WIDTH'(DEPTH));
  assign o_count = count_q;

endmodule

// File: rtl/tnoc_axi_master_read_bridge.sv
// Target-side read bridge: NoC read request headers become AXI AR bursts, R beats become
// response packets; requests to an invalid destination are answered locally with DECERR.
module tnoc_axi_master_read_bridge
  import tnoc_axi_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = 8,
  parameter int ID_X_WIDTH  = 3,
  parameter int ID_Y_WIDTH  = 3,
  parameter int VC_WIDTH    = 1,
  parameter int OUTSTANDING = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ID_X_WIDTH-1:0] i_id_x,
  input  logic [ID_Y_WIDTH-1:0] i_id_y,
  input  logic [VC_WIDTH-1:0]   i_vc,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ID_X_WIDTH-1:0] i_req_source_x,
  input  logic [ID_Y_WIDTH-1:0] i_req_source_y,
  input  logic [TAG_WIDTH-1:0]  i_req_tag,
  input  logic                  i_req_invalid_destination,
  input  logic [1:0]            i_req_burst_type,
  input  logic [7:0]            i_req_burst_length,
  input  logic [2:0]            i_req_burst_size,
  input  logic [ADDR_WIDTH-1:0] i_req_address,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  output logic [7:0]            o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic                  o_arid,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  output logic                  o_rsp_header_valid,
  input  logic                  i_rsp_header_ready,
  output logic [ID_X_WIDTH-1:0] o_rsp_destination_x,
  output logic [ID_Y_WIDTH-1:0] o_rsp_destination_y,
  output logic [ID_X_WIDTH-1:0] o_rsp_source_x,
  output logic [ID_Y_WIDTH-1:0] o_rsp_source_y,
  output logic [VC_WIDTH-1:0]   o_rsp_vc,
  output logic [TAG_WIDTH-1:0]  o_rsp_tag,
  output logic                  o_rsp_payload_valid,
  input  logic                  i_rsp_payload_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_payload_data,
  output logic [1:0]            o_rsp_payload_status,
  output logic                  o_rsp_payload_last
);

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_HEADER  = 2'd1;
  localparam logic [1:0] STATE_PAYLOAD = 2'd2;

  localparam int ENTRY_WIDTH         = $bits(tnoc_axi_read_tracker_entry);
  localparam int TRACKER_COUNT_WIDTH = $clog2(OUTSTANDING + 1);

  tnoc_axi_read_tracker_entry     push_entry;
  tnoc_axi_read_tracker_entry     head_entry;
  logic [ENTRY_WIDTH-1:0]         head_bits;
  logic                           tracker_pop;
  logic                           tracker_empty;
  logic                           tracker_full;
  logic [TRACKER_COUNT_WIDTH-1:0] tracker_count;
  logic                           req_accept;
  logic                           unused_head_bits;

  logic                  arvalid_q;
  logic                  arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [ADDR_WIDTH-1:0] araddr_d;
  logic [7:0]            arlen_q;
  logic [7:0]            arlen_d;
  logic [2:0]            arsize_q;
  logic [2:0]            arsize_d;
  logic [1:0]            arburst_q;
  logic [1:0]            arburst_d;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [7:0] beat_count_q;
  logic [7:0] beat_count_d;
  logic       payload_handshake;

  // A request is held off while an AR is still pending so the AR registers never get overwritten.
  assign o_req_ready = !arvalid_q && !tracker_full;
  assign req_accept  = i_req_valid && o_req_ready;

  always_comb begin
    push_entry          = '0;
    push_entry.source_x = TNOC_AXI_MAX_ID_WIDTH'(i_req_source_x);
    push_entry.source_y = TNOC_AXI_MAX_ID_WIDTH'(i_req_source_y);
    push_entry.tag      = TNOC_AXI_MAX_TAG_WIDTH'(i_req_tag);
    push_entry.error    = i_req_invalid_destination;
    push_entry.length   = i_req_burst_length;
  end

  tnoc_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (OUTSTANDING)
  ) u_tracker (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (req_accept),
    .i_data  (push_entry),
    .i_pop   (tracker_pop),
    .o_data  (head_bits),
    .o_empty (tracker_empty),
    .o_full  (tracker_full),
    .o_count (tracker_count)
  );

  assign head_entry       = tnoc_axi_read_tracker_entry'(head_bits);
  assign unused_head_bits = &{1'b0, head_bits};

  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    if (arvalid_q && i_arready) begin
      arvalid_d = 1'b0;
    end
    if (req_accept && !i_req_invalid_destination) begin
      arvalid_d = 1'b1;
      araddr_d  = i_req_address;
      arlen_d   = i_req_burst_length;
      arsize_d  = i_req_burst_size;
      arburst_d = i_req_burst_type;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
    end
  end

  assign o_arvalid = arvalid_q;
  assign o_araddr  = araddr_q;
  assign o_arlen   = arlen_q;
  assign o_arsize  = arsize_q;
  assign o_arburst = arburst_q;
  assign o_arid    = 1'b0;

  assign payload_handshake = o_rsp_payload_valid && i_rsp_payload_ready;

  // The tracker head always describes the response currently being emitted.
  always_comb begin
    state_d      = state_q;
    beat_count_d = beat_count_q;
    tracker_pop  = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (!tracker_empty) begin
          state_d = STATE_HEADER;
        end
      end
      STATE_HEADER: begin
        if (i_rsp_header_ready) begin
          state_d      = STATE_PAYLOAD;
          beat_count_d = head_entry.length;
        end
      end
      STATE_PAYLOAD: begin
        if (payload_handshake) begin
          if (o_rsp_payload_last) begin
            tracker_pop = 1'b1;
            state_d     = (tracker_count > TRACKER_COUNT_WIDTH'(1)) ? STATE_HEADER : STATE_IDLE;
          end else if (head_entry.error) begin
            beat_count_d = beat_count_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= STATE_IDLE;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign o_rsp_header_valid  = (state_q == STATE_HEADER);
  assign o_rsp_destination_x = head_entry.source_x[ID_X_WIDTH-1:0];
  assign o_rsp_destination_y = head_entry.source_y[ID_Y_WIDTH-1:0];
  assign o_rsp_source_x      = i_id_x;
  assign o_rsp_source_y      = i_id_y;
  assign o_rsp_vc            = i_vc;
  assign o_rsp_tag           = head_entry.tag[TAG_WIDTH-1:0];

  // Error entries synthesize their own beats and never touch the R channel.
  always_comb begin
    o_rsp_payload_valid  = 1'b0;
    o_rready             = 1'b0;
    o_rsp_payload_data   = '0;
    o_rsp_payload_status = '0;
    o_rsp_payload_last   = 1'b0;
    if (state_q == STATE_PAYLOAD) begin
      if (head_entry.error) begin
        o_rsp_payload_valid  = 1'b1;
        o_rsp_payload_status = TNOC_AXI_DECERR_RESP;
        o_rsp_payload_last   = (beat_count_q == 8'd0);
      end else begin
        o_rsp_payload_valid  = i_rvalid;
        o_rready             = i_rsp_payload_ready;
        o_rsp_payload_data   = i_rdata;
        o_rsp_payload_status = i_rresp;
        o_rsp_payload_last   = i_rlast;
      end
    end
  end

endmodule

// File: tb/tb_tnoc_axi_master_read_bridge.sv
// Bench for tnoc_axi_master_read_bridge: random read requests, a small AXI memory and a
// response sink, with every packet compared against a request-ordered expectation queue.
module tb_tnoc_axi_master_read_bridge;

  localparam logic [2:0] OWN_X  = 3'd5;
  localparam logic [2:0] OWN_Y  = 3'd6;
  localparam logic       OWN_VC = 1'b1;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        reqValid = 1'b0;
  logic        oReqReady;
  logic [2:0]  reqSourceX = '0;
  logic [2:0]  reqSourceY = '0;
  logic [7:0]  reqTag = '0;
  logic        reqInvalidDest = 1'b0;
  logic [1:0]  reqBurstType = '0;
  logic [7:0]  reqBurstLength = '0;
  logic [2:0]  reqBurstSize = '0;
  logic [31:0] reqAddress = '0;
  logic        oArvalid;
  logic        arready = 1'b0;
  logic [31:0] oAraddr;
  logic [7:0]  oArlen;
  logic [2:0]  oArsize;
  logic [1:0]  oArburst;
  logic        oArid;
  logic        rvalid = 1'b0;
  logic        oRready;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        oHdrValid;
  logic        hdrReady = 1'b1;
  logic [2:0]  oDestX;
  logic [2:0]  oDestY;
  logic [2:0]  oSrcX;
  logic [2:0]  oSrcY;
  logic        oVc;
  logic [7:0]  oTag;
  logic        oPayValid;
  logic        payReady = 1'b1;
  logic [63:0] oPayData;
  logic [1:0]  oPayStatus;
  logic        oPayLast;

  always #5 clk = ~clk;

  tnoc_axi_master_read_bridge dut (
    .i_clk(clk), .i_rst_n(rstN), .i_id_x(OWN_X), .i_id_y(OWN_Y), .i_vc(OWN_VC),
    .i_req_valid(reqValid), .o_req_ready(oReqReady),
    .i_req_source_x(reqSourceX), .i_req_source_y(reqSourceY), .i_req_tag(reqTag),
    .i_req_invalid_destination(reqInvalidDest), .i_req_burst_type(reqBurstType),
    .i_req_burst_length(reqBurstLength), .i_req_burst_size(reqBurstSize),
    .i_req_address(reqAddress),
    .o_arvalid(oArvalid), .i_arready(arready), .o_araddr(oAraddr), .o_arlen(oArlen),
    .o_arsize(oArsize), .o_arburst(oArburst), .o_arid(oArid),
    .i_rvalid(rvalid), .o_rready(oRready), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast),
    .o_rsp_header_valid(oHdrValid), .i_rsp_header_ready(hdrReady),
    .o_rsp_destination_x(oDestX), .o_rsp_destination_y(oDestY),
    .o_rsp_source_x(oSrcX), .o_rsp_source_y(oSrcY), .o_rsp_vc(oVc), .o_rsp_tag(oTag),
    .o_rsp_payload_valid(oPayValid), .i_rsp_payload_ready(payReady),
    .o_rsp_payload_data(oPayData), .o_rsp_payload_status(oPayStatus),
    .o_rsp_payload_last(oPayLast)
  );

  typedef struct {
    logic [2:0]  sx;
    logic [2:0]  sy;
    logic [7:0]  tag;
    logic        err;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] addr;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;

  req_t        expQ[$];
  logic [44:0] expArQ[$];
  logic [44:0] obsArQ[$];
  logic [20:0] hdrQ[$];
  logic [66:0] beatQ[$];
  int          lastCycleQ[$];

  int arDelay = 0;
  bit rEnable = 1'b1;
  int payMode = 0;
  bit hdrRandom = 1'b0;

  // Memory contents are a fixed function of address and beat so expectations follow from the request.
  function automatic logic [63:0] rdataOf(input logic [31:0] addr, input int beat);
    return {addr ^ 32'hC0DE_0000, addr + 32'(beat) * 32'h9E37_79B9};
  endfunction

  function automatic logic [1:0] rrespOf(input logic [31:0] addr, input int beat);
    logic [1:0] b;
    b = beat[1:0];
    return addr[9:8] + b;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  always @(posedge clk) cycleCnt++;

  // Response sink: header and payload ready patterns selected by the running test step.
  always begin
    @(negedge clk);
    hdrReady = hdrRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    case (payMode)
      1:       payReady = ~payReady;
      2:       payReady = 1'($urandom_range(0, 1));
      default: payReady = 1'b1;
    endcase
  end

  // AXI memory slave: accepts AR after arDelay cycles, returns bursts in AR order when enabled,
  // and watches that the AR fields stay put while the address is waiting.
  ar_t         arPend[$];
  int          beatIdx = 0;
  int          arWait = 0;
  bit          arHeld = 1'b0;
  logic [44:0] arHeldVal;
  always begin
    @(negedge clk);
    if (!rstN) begin
      arPend.delete();
      beatIdx = 0;
      arWait  = 0;
      arHeld  = 1'b0;
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rdata   = '0;
      rresp   = '0;
    end else begin
      arready = oArvalid && (arWait >= arDelay);
      if (rEnable && arPend.size() > 0) begin
        rvalid = 1'b1;
        rdata  = rdataOf(arPend[0].addr, beatIdx);
        rresp  = rrespOf(arPend[0].addr, beatIdx);
        rlast  = (beatIdx == int'(arPend[0].len));
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = '0;
        rresp  = '0;
      end
      #1;
      if (oArvalid) begin
        if (arHeld) checkOutput("ar_stable", {oAraddr, oArlen, oArsize, oArburst}, arHeldVal);
        if (arready) begin
          obsArQ.push_back({oAraddr, oArlen, oArsize, oArburst});
          arPend.push_back('{addr: oAraddr, len: oArlen});
          arWait = 0;
          arHeld = 1'b0;
        end else begin
          arWait++;
          arHeld    = 1'b1;
          arHeldVal = {oAraddr, oArlen, oArsize, oArburst};
        end
      end else begin
        arHeld = 1'b0;
      end
      if (oRready) checkOutput("rready_mirror", payReady, 1'b1);
      if (rvalid && oRready) begin
        if (rlast) begin
          void'(arPend.pop_front());
          beatIdx = 0;
        end else begin
          beatIdx++;
        end
      end
    end
  end

  // Response monitor: records every accepted header and payload beat.
  always begin
    @(negedge clk);
    #1;
    if (rstN) begin
      if (oHdrValid && hdrReady) hdrQ.push_back({oDestX, oDestY, oSrcX, oSrcY, oVc, oTag});
      if (oPayValid && payReady) begin
        beatQ.push_back({oPayData, oPayStatus, oPayLast});
        if (oPayLast) lastCycleQ.push_back(cycleCnt);
      end
    end
  end

  function automatic req_t randReq(input logic [7:0] tag, input bit err);
    req_t r;
    r.sx    = 3'($urandom_range(0, 7));
    r.sy    = 3'($urandom_range(0, 7));
    r.tag   = tag;
    r.err   = err;
    r.len   = 8'($urandom_range(0, 7));
    r.size  = 3'($urandom_range(0, 3));
    r.burst = 2'($urandom_range(0, 2));
    r.addr  = $urandom;
    return r;
  endfunction

  task automatic driveReq(input req_t r);
    reqValid       = 1'b1;
    reqSourceX     = r.sx;
    reqSourceY     = r.sy;
    reqTag         = r.tag;
    reqInvalidDest = r.err;
    reqBurstLength = r.len;
    reqBurstSize   = r.size;
    reqBurstType   = r.burst;
    reqAddress     = r.addr;
  endtask

  task automatic recordReq(input req_t r);
    expQ.push_back(r);
    if (!r.err) expArQ.push_back({r.addr, r.len, r.size, r.burst});
  endtask

  task automatic applyStimulus(input req_t r);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    driveReq(r);
    for (int i = 0; i < 400 && !ok; i++) begin
      #1;
      if (oReqReady) ok = 1'b1;
      else @(negedge clk);
    end
    checkOutput("req_accept", ok, 1'b1);
    @(negedge clk);
    reqValid = 1'b0;
    if (ok) recordReq(r);
  endtask

  task automatic waitDrain();
    int needBeats;
    bit done;
    needBeats = 0;
    done = 1'b0;
    foreach (expQ[i]) needBeats += int'(expQ[i].len) + 1;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      #2;
      if (hdrQ.size() >= expQ.size() && beatQ.size() >= needBeats && obsArQ.size() >= expArQ.size())
        done = 1'b1;
    end
    if (!done) checkOutput("drain_timeout", beatQ.size(), needBeats);
    repeat (4) @(negedge clk);
    #2;
  endtask

  task automatic checkResponses(input string name);
    req_t        e;
    logic [20:0] gotHdr;
    logic [66:0] gotBeat;
    logic [66:0] expBeat;
    logic [44:0] gotAr;
    logic [44:0] wantAr;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      gotHdr = (hdrQ.size() > 0) ? hdrQ.pop_front() : 'x;
      checkOutput({name, "_hdr"}, gotHdr, {e.sx, e.sy, OWN_X, OWN_Y, OWN_VC, e.tag});
      for (int b = 0; b <= int'(e.len); b++) begin
        if (e.err) expBeat = {64'd0, 2'd3, b == int'(e.len)};
        else       expBeat = {rdataOf(e.addr, b), rrespOf(e.addr, b), b == int'(e.len)};
        gotBeat = (beatQ.size() > 0) ? beatQ.pop_front() : 'x;
        checkOutput({name, "_beat"}, gotBeat, expBeat);
      end
    end
    while (expArQ.size() > 0) begin
      wantAr = expArQ.pop_front();
      gotAr  = (obsArQ.size() > 0) ? obsArQ.pop_front() : 'x;
      checkOutput({name, "_ar"}, gotAr, wantAr);
    end
    checkOutput({name, "_extra"}, hdrQ.size() + beatQ.size() + obsArQ.size(), 0);
    hdrQ.delete();
    beatQ.delete();
    obsArQ.delete();
  endtask

  initial begin
    req_t r;
    int   lastBase;
    int   acceptCycle;
    bit   accepted;
    bit   seen;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_req_ready", oReqReady, 1'b1);
    checkOutput("rst_arvalid", oArvalid, 1'b0);
    checkOutput("rst_araddr", oAraddr, 32'd0);
    checkOutput("rst_arlen", oArlen, 8'd0);
    checkOutput("rst_arid", oArid, 1'b0);
    checkOutput("rst_hdr_valid", oHdrValid, 1'b0);
    checkOutput("rst_pay_valid", oPayValid, 1'b0);
    checkOutput("rst_rready", oRready, 1'b0);
    @(negedge clk);
    rstN = 1'b1;

    // Single normal read
    r = '{sx: 3'd1, sy: 3'd2, tag: 8'h12, err: 1'b0, len: 8'd3, size: 3'd3, burst: 2'd1, addr: 32'h1000};
    applyStimulus(r);
    waitDrain();
    checkResponses("single");

    // Decode error answered locally
    r = '{sx: 3'd4, sy: 3'd3, tag: 8'h34, err: 1'b1, len: 8'd1, size: 3'd3, burst: 2'd1, addr: 32'h2000};
    applyStimulus(r);
    waitDrain();
    checkResponses("decerr");

    // Mixed normal / error / normal ordering
    applyStimulus(randReq(8'd1, 1'b0));
    applyStimulus(randReq(8'd2, 1'b1));
    applyStimulus(randReq(8'd3, 1'b0));
    waitDrain();
    checkResponses("mixed");

    // Backpressure: toggling and random payload ready, slow AR acceptance
    arDelay   = 5;
    hdrRandom = 1'b1;
    payMode   = 1;
    for (int i = 0; i < 6; i++) applyStimulus(randReq(8'(8'h40 + i), $urandom_range(0, 3) == 0));
    waitDrain();
    checkResponses("bp_toggle");
    payMode = 2;
    for (int i = 0; i < 6; i++) applyStimulus(randReq(8'(8'h50 + i), $urandom_range(0, 3) == 0));
    waitDrain();
    checkResponses("bp_random");
    arDelay   = 0;
    hdrRandom = 1'b0;
    payMode   = 0;

    // Full tracker with R withheld
    rEnable = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(randReq(8'(8'h60 + i), 1'b0));
    repeat (6) @(negedge clk);
    r = randReq(8'h64, 1'b0);
    driveReq(r);
    repeat (8) @(negedge clk);
    #1;
    checkOutput("full_req_ready", oReqReady, 1'b0);
    lastBase    = lastCycleQ.size();
    rEnable     = 1'b1;
    accepted    = 1'b0;
    acceptCycle = 0;
    for (int i = 0; i < 500 && !accepted; i++) begin
      @(negedge clk);
      #1;
      if (oReqReady) begin
        accepted    = 1'b1;
        acceptCycle = cycleCnt;
      end
    end
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("full_accept", accepted, 1'b1);
    checkOutput("full_after_pop", lastCycleQ.size() > lastBase && acceptCycle > lastCycleQ[lastBase], 1'b1);
    if (accepted) recordReq(r);
    waitDrain();
    checkResponses("full");

    // Asynchronous reset in the middle of a payload
    r = randReq(8'h77, 1'b0);
    r.len = 8'd7;
    applyStimulus(r);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (beatQ.size() >= 2) seen = 1'b1;
    end
    checkOutput("rst_mid_payload_reached", beatQ.size() >= 2, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("arst_hdr_valid", oHdrValid, 1'b0);
    checkOutput("arst_pay_valid", oPayValid, 1'b0);
    checkOutput("arst_arvalid", oArvalid, 1'b0);
    checkOutput("arst_rready", oRready, 1'b0);
    checkOutput("arst_req_ready", oReqReady, 1'b1);
    expQ.delete();
    expArQ.delete();
    hdrQ.delete();
    beatQ.delete();
    obsArQ.delete();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    applyStimulus(randReq(8'h88, 1'b0));
    waitDrain();
    checkResponses("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tnoc_axi_master_read_bridge.md
Name: tnoc_axi_master_read_bridge

Overview:
- Target-side counterpart of the AXI slave read adapter; sits between the NoC packet deserializer/serializer pair and an AXI memory slave.
- Consumes deserialized READ request headers and issues AXI AR bursts.
- Returns R beats as a response packet: header followed by payload beats.
- Requests with invalid_destination get a locally generated DECERR burst; no AR is issued for them.

Parameters:
- ADDR_WIDTH, 32, AXI/NoC address width
- DATA_WIDTH, 64, rdata/payload width
- TAG_WIDTH, 8, NoC tag width (carries master arid)
- ID_X_WIDTH, 3, location id x width
- ID_Y_WIDTH, 3, location id y width
- VC_WIDTH, 1, virtual channel width
- OUTSTANDING, 4, max requests in flight (tracker depth, >=1)

Ports:
- i_clk in 1 clock
- i_rst_n in 1 async active-low reset
- i_id_x / i_id_y in ID_X_WIDTH / ID_Y_WIDTH own location id
- i_vc in VC_WIDTH response vc
- i_req_valid in 1 / o_req_ready out 1 request header handshake
- i_req_source_x / i_req_source_y in ID_X_WIDTH / ID_Y_WIDTH requester id
- i_req_tag in TAG_WIDTH
- i_req_invalid_destination in 1
- i_req_burst_type in 2; i_req_burst_length in 8 (beats-1); i_req_burst_size in 3; i_req_address in ADDR_WIDTH
- o_arvalid out 1; i_arready in 1; o_araddr out ADDR_WIDTH; o_arlen out 8; o_arsize out 3; o_arburst out 2; o_arid out 1 (tied 0)
- i_rvalid in 1; o_rready out 1; i_rdata in DATA_WIDTH; i_rresp in 2; i_rlast in 1
- o_rsp_header_valid out 1 / i_rsp_header_ready in 1
- o_rsp_destination_x / o_rsp_destination_y out ID_X_WIDTH / ID_Y_WIDTH
- o_rsp_source_x / o_rsp_source_y out ID_X_WIDTH / ID_Y_WIDTH
- o_rsp_vc out VC_WIDTH; o_rsp_tag out TAG_WIDTH
- o_rsp_payload_valid out 1 / i_rsp_payload_ready in 1
- o_rsp_payload_data out DATA_WIDTH; o_rsp_payload_status out 2; o_rsp_payload_last out 1

Behaviour:
- Reset: all valid outputs 0; tracker empty; FSM IDLE; beat counter 0; AR registers 0.
- Request accept: i_req_valid && o_req_ready, where o_req_ready = !o_arvalid && !tracker_full. Combinational, no bypass.
- On accept:
  - Push entry {source_x, source_y, tag, error=invalid_destination, length} to the tracker.
  - If !error: register AR fields (arlen=burst_length, arsize, arburst, araddr); o_arvalid rises the next cycle and holds, fields stable, until i_arready.
- Single AXI ID, so R returns in AR order; tracker order equals response order.
- Response FSM: IDLE -> HEADER when tracker non-empty (header valid 1 cycle after the push is visible).
  - HEADER: o_rsp_header_valid=1; destination=entry source, source={i_id_x,i_id_y}, vc=i_vc, tag=entry tag. On i_rsp_header_ready -> PAYLOAD.
  - PAYLOAD, normal entry: o_rsp_payload_valid=i_rvalid; o_rready=i_rsp_payload_ready; data=i_rdata; status=i_rresp (OKAY 0, EXOKAY 1, SLVERR 2, DECERR 3 unchanged); last=i_rlast. On handshake with i_rlast: pop, -> HEADER if another entry is present, else IDLE.
  - PAYLOAD, error entry: o_rready=0. Counter loads length on HEADER exit. Emits beats with valid=1, data=0, status=3, last=(counter==0); decrement per handshake; pop on last.
- o_rready=0 outside PAYLOAD; R beats arriving early stall.
- Tracker full (OUTSTANDING entries): o_req_ready=0. A pop in the same cycle does not enable a push.
- i_rlast is authoritative for normal entries; no beat-count check.
- Reset mid-burst: all state dropped; external AXI slave reset together.

Decomposition:
- tnoc_axi_pkg gains tnoc_axi_read_tracker_entry struct and a DECERR constant; reuse the existing tnoc_axi_response enum.
- Tracker is a sub-module instance of the existing generic tnoc_fifo (DEPTH=OUTSTANDING); FSM and AR register stay in this module.

Test Plan:
- Single read: tag 0x12, src (1,2), addr 0x1000, len 3 -> one AR (arlen 3); header dest (1,2) tag 0x12; 4 payload beats with R data, last on beat 4.
- Decode error: len 1, invalid_destination=1 -> no AR; header then 2 beats data 0, status 3, last on beat 2.
- Mixed order: normal(tag 1), error(tag 2), normal(tag 3) -> responses strictly tag 1, 2, 3; error beats never consume R.
- Backpressure: i_rsp_payload_ready toggles 1/0 and i_arready delayed 5 cycles -> o_rready mirrors ready, no beat lost or duplicated, AR fields stable while o_arvalid.
- Full tracker: OUTSTANDING=4, 5 requests, R withheld -> 5th sees o_req_ready=0 until first response's last beat pops.
- Async reset asserted mid-payload -> all valids 0 immediately; after release a new request completes normally.
